// File: rtl/vbs_video_gen_if.sv
// rtl/vbs_video_gen_if.sv - CPU strobe/write port into the video framebuffer
interface vbs_video_gen_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dataIn;
  logic              strobe;
  logic              write;
  logic [7:0]        dataOut;

  modport master (output addr, dataIn, strobe, write, input dataOut);
  modport slave  (input addr, dataIn, strobe, write, output dataOut);
endinterface

// File: rtl/vbs_video_gen.sv
// rtl/vbs_video_gen.sv - composite sync / 1-bpp pixel generator with byte-wide framebuffer
module vbs_video_gen #(
  parameter int H_TOTAL       = 256,
  parameter int V_TOTAL       = 313,
  parameter int H_SYNC_LEN    = 14,
  parameter int V_SYNC_LINES  = 3,
  parameter int H_START       = 48,
  parameter int V_START       = 35,
  parameter int BYTES_PER_ROW = 16,
  parameter int ROWS          = 128,
  parameter int Y_SCALE_LOG2  = 1,
  localparam int COL_W        = $clog2(BYTES_PER_ROW),
  localparam int ROW_W        = $clog2(ROWS),
  localparam int ADDR_W       = ROW_W + COL_W
) (
  input  logic             clk,
  input  logic             reset_n,
  vbs_video_gen_if.slave   cpu,
  input  logic [ROW_W-1:0] scroll,
  input  logic             invert,
  input  logic             enable,
  output logic             sync,
  output logic             pixel,
  output logic             frameStart
);
  localparam int HW   = $clog2(H_TOTAL);
  localparam int VW   = $clog2(V_TOTAL);
  localparam int XC_W = COL_W + 3;
  localparam int YL_W = ROW_W + Y_SCALE_LOG2;

  localparam logic [HW-1:0]   H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_SYNC_END = HW'(H_SYNC_LEN);
  localparam logic [HW-1:0]   H_OPEN     = HW'(H_START);
  localparam logic [VW-1:0]   V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_BROAD    = VW'(V_SYNC_LINES);
  localparam logic [VW-1:0]   V_PRE      = VW'(V_START - 1);
  localparam logic [XC_W-1:0] X_LAST     = XC_W'(8 * BYTES_PER_ROW - 1);
  localparam logic [YL_W-1:0] Y_LAST     = YL_W'((ROWS << Y_SCALE_LOG2) - 1);

  logic [7:0]        ram [2**ADDR_W];

  logic [HW-1:0]     hCounter;
  logic [VW-1:0]     vCounter;
  logic [YL_W-1:0]   yLine;
  logic [XC_W-1:0]   xCounter;
  logic              yRange;
  logic              xRange;
  logic              visible;
  logic [7:0]        shift;
  logic [ROW_W-1:0]  scroll_sh;
  logic              invert_sh;
  logic              enable_sh;

  logic              line_end;
  logic              frame_wrap;
  logic              sync_span;
  logic [ROW_W-1:0]  disp_row;
  logic [ADDR_W-1:0] fetch_addr;

  assign line_end   = (hCounter == H_LAST);
  assign frame_wrap = line_end && (vCounter == V_LAST);
  assign sync_span  = (hCounter >= HW'(1)) && (hCounter <= H_SYNC_END);
  assign disp_row   = ROW_W'(yLine >> Y_SCALE_LOG2) + scroll_sh;
  assign fetch_addr = {disp_row, xCounter[XC_W-1:3]};

  // visible trails xRange by one cycle, covering the fetch latency of byte 0
  assign pixel = visible & enable_sh & (shift[7] ^ invert_sh);

  always_ff @(posedge clk) begin
    if (cpu.strobe && cpu.write) begin
      ram[cpu.addr] <= cpu.dataIn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCounter    <= '0;
      vCounter    <= '0;
      yLine       <= '0;
      xCounter    <= '0;
      yRange      <= 1'b0;
      xRange      <= 1'b0;
      visible     <= 1'b0;
      shift       <= '0;
      scroll_sh   <= '0;
      invert_sh   <= 1'b0;
      enable_sh   <= 1'b0;
      sync        <= 1'b1;
      frameStart  <= 1'b0;
      cpu.dataOut <= '0;
    end else begin
      if (line_end) begin
        hCounter <= '0;
        vCounter <= (vCounter == V_LAST) ? '0 : vCounter + 1'b1;
      end else begin
        hCounter <= hCounter + 1'b1;
      end

      // broad-sync lines carry the inverted pulse
      sync       <= (vCounter < V_BROAD) ? sync_span : !sync_span;
      frameStart <= frame_wrap;

      if (frame_wrap) begin
        scroll_sh <= scroll;
        invert_sh <= invert;
        enable_sh <= enable;
      end

      if (line_end) begin
        if (vCounter == V_PRE) begin
          yRange <= 1'b1;
          yLine  <= '0;
        end else if (yRange) begin
          if (yLine == Y_LAST) begin
            yRange <= 1'b0;
          end
          yLine <= yLine + 1'b1;
        end
      end

      if (yRange && (hCounter == H_OPEN)) begin
        xRange   <= 1'b1;
        xCounter <= '0;
      end else if (xRange) begin
        if (xCounter == X_LAST) begin
          xRange <= 1'b0;
        end
        xCounter <= xCounter + 1'b1;
      end

      visible <= xRange;

      if (xRange && (xCounter[2:0] == 3'd0)) begin
        shift <= ram[fetch_addr];
      end else begin
        shift <= {shift[6:0], 1'b0};
      end

      if (cpu.strobe && !cpu.write) begin
        cpu.dataOut <= ram[cpu.addr];
      end
    end
  end
endmodule

// File: tb/tb_vbs_video_gen.sv
// tb/tb_vbs_video_gen.sv - self-checking bench for vbs_video_gen on a reduced raster
module tb_vbs_video_gen;
  localparam int H_TOTAL       = 48;
  localparam int V_TOTAL       = 40;
  localparam int H_SYNC_LEN    = 6;
  localparam int V_SYNC_LINES  = 3;
  localparam int H_START       = 20;
  localparam int V_START       = 6;
  localparam int BYTES_PER_ROW = 2;
  localparam int ROWS          = 8;
  localparam int Y_SCALE_LOG2  = 1;
  localparam int ROW_W         = 3;
  localparam int ADDR_W        = 4;
  localparam int X_PIXELS      = 8 * BYTES_PER_ROW;
  localparam int ACTIVE_LINES  = ROWS << Y_SCALE_LOG2;
  localparam int NBYTES        = ROWS * BYTES_PER_ROW;
  localparam int FRAME         = H_TOTAL * V_TOTAL;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [ROW_W-1:0] scroll = '0;
  logic             invert = 1'b0;
  logic             enable = 1'b0;
  logic             sync;
  logic             pixel;
  logic             frameStart;

  vbs_video_gen_if #(.ADDR_W(ADDR_W)) cpu ();

  vbs_video_gen #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_SYNC_LEN(H_SYNC_LEN),
    .V_SYNC_LINES(V_SYNC_LINES), .H_START(H_START), .V_START(V_START),
    .BYTES_PER_ROW(BYTES_PER_ROW), .ROWS(ROWS), .Y_SCALE_LOG2(Y_SCALE_LOG2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu(cpu), .scroll(scroll), .invert(invert),
    .enable(enable), .sync(sync), .pixel(pixel), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               tb_h;
  int               tb_v;
  logic [ROW_W-1:0] sh_scroll;
  logic             sh_inv;
  logic             sh_en;
  logic [7:0]       mem [NBYTES];
  logic             pix_q[$];
  logic [7:0]       rd_q[$];

  // raster position and frame-latched controls of the bench's own model
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tb_h <= 0; tb_v <= 0; sh_scroll <= '0; sh_inv <= 1'b0; sh_en <= 1'b0;
    end else if (tb_h == H_TOTAL - 1) begin
      tb_h <= 0;
      if (tb_v == V_TOTAL - 1) begin
        tb_v <= 0; sh_scroll <= scroll; sh_inv <= invert; sh_en <= enable;
      end else begin
        tb_v <= tb_v + 1;
      end
    end else begin
      tb_h <= tb_h + 1;
    end
  end

  function automatic logic exp_pixel(int v, int h);
    int row, x;
    logic [7:0] b;
    if (v < V_START || v >= V_START + ACTIVE_LINES) return 1'b0;
    if (h < H_START + 2 || h >= H_START + 2 + X_PIXELS) return 1'b0;
    row = (((v - V_START) >> Y_SCALE_LOG2) + int'(sh_scroll)) % ROWS;
    x = h - H_START - 2;
    b = mem[row * BYTES_PER_ROW + x / 8];
    return sh_en & (b[7 - (x % 8)] ^ sh_inv);
  endfunction

  function automatic logic exp_sync(int v, int h);
    int ph, pv;
    logic span;
    ph = (h == 0) ? H_TOTAL - 1 : h - 1;
    pv = (h == 0) ? v - 1 : v;
    span = (ph >= 1) && (ph <= H_SYNC_LEN);
    return (pv < V_SYNC_LINES) ? span : !span;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_to(int v, int h);
    int n = 0;
    while (!(tb_v == v && tb_h == h) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    if (!(tb_v == v && tb_h == h)) begin
      checks++; errors++;
      $display("FAIL wait_to: position %0d/%0d, required %0d/%0d", tb_v, tb_h, v, h);
    end
  endtask

  task automatic next_frame();
    wait_to(V_TOTAL - 1, 0);
    wait_to(0, 0);
  endtask

  task automatic cpu_write(int a, logic [7:0] d);
    cpu.addr = ADDR_W'(a); cpu.dataIn = d; cpu.strobe = 1'b1; cpu.write = 1'b1;
    mem[a] = d;
    tick();
    cpu.strobe = 1'b0; cpu.write = 1'b0;
  endtask

  task automatic check_line(int v);
    logic e;
    wait_to(v, 0);
    for (int h = 0; h < H_TOTAL; h++) pix_q.push_back(exp_pixel(v, h));
    for (int h = 0; h < H_TOTAL; h++) begin
      e = pix_q.pop_front();
      checks++;
      if (pixel !== e) begin
        errors++;
        $display("FAIL pixel line %0d h %0d: got %b, required %b", v, h, pixel, e);
      end
      tick();
    end
  endtask

  task automatic check_sync_line(int v);
    wait_to(v, 0);
    for (int h = 0; h < H_TOTAL; h++) begin
      checks++;
      if (sync !== exp_sync(v, h)) begin
        errors++;
        $display("FAIL sync line %0d h %0d: got %b, required %b", v, h, sync, exp_sync(v, h));
      end
      tick();
    end
  endtask

  task automatic test_reset();
    cpu.addr = '0; cpu.dataIn = '0; cpu.strobe = 1'b0; cpu.write = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks += 4;
    if (sync !== 1'b1)       begin errors++; $display("FAIL reset sync: got %b, required 1", sync); end
    if (pixel !== 1'b0)      begin errors++; $display("FAIL reset pixel: got %b, required 0", pixel); end
    if (frameStart !== 1'b0) begin errors++; $display("FAIL reset frameStart: got %b, required 0", frameStart); end
    if (cpu.dataOut !== 8'h00) begin errors++; $display("FAIL reset dataOut: got %h, required 00", cpu.dataOut); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sync_frame();
    logic e;
    for (int n = 0; n <= 2 * FRAME; n++) begin
      if (tb_v == 1 || tb_v == 5) begin
        checks++;
        if (sync !== exp_sync(tb_v, tb_h)) begin
          errors++;
          $display("FAIL sync line %0d h %0d: got %b, required %b", tb_v, tb_h, sync, exp_sync(tb_v, tb_h));
        end
      end
      e = (n == FRAME) || (n == 2 * FRAME);
      checks++;
      if (frameStart !== e) begin
        errors++;
        $display("FAIL frameStart cycle %0d: got %b, required %b", n, frameStart, e);
      end
      if (n != 2 * FRAME) tick();
    end
  endtask

  task automatic test_pixels();
    for (int a = 0; a < NBYTES; a++) cpu_write(a, 8'h00);
    cpu_write(0, 8'h81);
    cpu_write(2, 8'h3C); cpu_write(3, 8'hC3);
    cpu_write(4, 8'h55); cpu_write(5, 8'hAA);
    cpu_write(14, 8'hF0); cpu_write(15, 8'h0F);
    scroll = '0; invert = 1'b0; enable = 1'b1;
    next_frame();
    check_line(V_START - 1);
    check_line(V_START);
    check_line(V_START + 1);
    check_line(V_START + 2);
  endtask

  task automatic test_scroll();
    scroll = 3'd7;
    check_line(V_START + 4);
    next_frame();
    check_line(V_START);
    check_line(V_START + 2);
  endtask

  task automatic test_collision();
    logic e;
    wait_to(V_START + 4, 0);
    for (int h = 0; h < H_TOTAL; h++) pix_q.push_back(exp_pixel(V_START + 4, h));
    for (int h = 0; h < H_TOTAL; h++) begin
      e = pix_q.pop_front();
      checks++;
      if (pixel !== e) begin
        errors++;
        $display("FAIL collision line h %0d: got %b, required %b", h, pixel, e);
      end
      if (h == H_START + 1) begin
        cpu.addr = ADDR_W'(2); cpu.dataIn = 8'hFF; cpu.strobe = 1'b1; cpu.write = 1'b1;
      end
      tick();
      cpu.strobe = 1'b0; cpu.write = 1'b0;
    end
    mem[2] = 8'hFF;
    check_line(V_START + 5);
  endtask

  task automatic test_invert();
    for (int a = 0; a < NBYTES; a++) cpu_write(a, 8'h00);
    scroll = '0; invert = 1'b1; enable = 1'b1;
    next_frame();
    check_line(V_START - 1);
    check_line(V_START);
    check_line(V_START + ACTIVE_LINES - 1);
    check_line(V_START + ACTIVE_LINES);
  endtask

  task automatic test_enable();
    cpu_write(0, 8'h81);
    enable = 1'b0;
    next_frame();
    check_sync_line(1);
    check_sync_line(5);
    check_line(V_START);
    check_line(V_START + 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int addrs[5] = '{15, 15, 0, 2, 14};
    cpu_write(15, 8'h5A);
    cpu_write(2, 8'h33);
    cpu_write(14, 8'hC7);
    for (int i = 0; i < 5; i++) begin
      cpu.addr = ADDR_W'(addrs[i]); cpu.strobe = 1'b1; cpu.write = 1'b0;
      rd_q.push_back(mem[addrs[i]]);
      tick();
      e = rd_q.pop_front();
      checks++;
      if (cpu.dataOut !== e) begin
        errors++;
        $display("FAIL read addr %0d: got %h, required %h", addrs[i], cpu.dataOut, e);
      end
    end
    cpu.strobe = 1'b0;
    cpu.addr = ADDR_W'(0);
    repeat (2) tick();
    checks++;
    if (cpu.dataOut !== 8'hC7) begin
      errors++;
      $display("FAIL read hold: got %h, required c7", cpu.dataOut);
    end
  endtask

  task automatic test_async_reset();
    int n;
    invert = 1'b1; enable = 1'b1;
    next_frame();
    wait_to(10, H_START + 5);
    checks++;
    if (pixel !== exp_pixel(10, H_START + 5)) begin
      errors++;
      $display("FAIL pre-reset pixel: got %b, required %b", pixel, exp_pixel(10, H_START + 5));
    end
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (sync !== 1'b1)       begin errors++; $display("FAIL async sync: got %b, required 1", sync); end
    if (pixel !== 1'b0)      begin errors++; $display("FAIL async pixel: got %b, required 0", pixel); end
    if (frameStart !== 1'b0) begin errors++; $display("FAIL async frameStart: got %b, required 0", frameStart); end
    if (cpu.dataOut !== 8'h00) begin errors++; $display("FAIL async dataOut: got %h, required 00", cpu.dataOut); end
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (frameStart !== 1'b1 && n < FRAME + 5) begin
      tick();
      n++;
    end
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("FAIL restart frameStart delay: got %0d, required %0d", n, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_sync_frame();
    test_pixels();
    test_scroll();
    test_collision();
    test_invert();
    test_enable();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
